// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared FSM encoding and PC constants for instruction fetch
package instruction_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam int PC_STEP  = 4;
  localparam int RESET_PC = 0;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small FIFO holding fetched {instruction, pc} pairs
module fetch_queue #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage is cleared on reset so the head output reads as zero before any fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC sequencing, redirect handling and queued delivery of instructions
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int BITS        = 32,
  parameter int i_addr_bits = 6,
  parameter int QDEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  output logic [i_addr_bits-3:0] imem_addr,
  input  logic [BITS-1:0]        imem_dout,
  input  logic                   redirect_valid,
  input  logic [i_addr_bits-1:0] redirect_pc,
  output logic [BITS-1:0]        instr,
  output logic [i_addr_bits-1:0] instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready
);

  fetch_state_t           state_q;
  fetch_state_t           state_d;
  logic [i_addr_bits-1:0] pc_q;
  logic                   q_full;
  logic                   q_empty;
  logic                   pop;
  logic                   fetch;

  assign imem_addr   = pc_q[i_addr_bits-1:2];
  assign instr_valid = !q_empty;

  // Redirect suppresses both the transfer and the fetch in its cycle.
  assign pop   = instr_valid && instr_ready && !redirect_valid;
  assign fetch = (state_q == RUN) && fetch_en && !redirect_valid && (!q_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!redirect_valid) begin
      case (state_q)
        IDLE:    if (fetch_en)  state_d = RUN;
        RUN:     if (!fetch_en) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc_q <= i_addr_bits'(RESET_PC);
    else if (redirect_valid) pc_q <= redirect_pc & ~i_addr_bits'(3);
    else if (fetch)          pc_q <= pc_q + i_addr_bits'(PC_STEP);
  end

  fetch_queue #(
    .WIDTH (BITS + i_addr_bits),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({imem_dout, pc_q}),
    .dout  ({instr, instr_pc}),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed table, corner sequences and random run against a queue model
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [3:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_pc = '0;
  logic [31:0] instr;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  logic [31:0] mem [16];
  assign imem_dout = mem[imem_addr];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] i;
    logic [5:0]  p;
  } ent_t;

  ent_t       mq[$];
  logic [5:0] mpc = '0;
  bit         mrun = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a list of fetched words, a pc that steps by 4 modulo 64, and a running flag.
  task automatic model_step();
    bit   xfer;
    bit   fch;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      mpc  = '0;
      mrun = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc & 6'h3C;
    end else begin
      xfer = (mq.size() > 0) && instr_ready;
      fch  = mrun && fetch_en && ((mq.size() < 2) || xfer);
      e.i  = mem[mpc >> 2];
      e.p  = mpc;
      if (xfer) void'(mq.pop_front());
      if (fch) begin
        mq.push_back(e);
        mpc = mpc + 6'd4;
      end
      mrun = fetch_en;
    end
  endtask

  task automatic model_check();
    chk("valid", 64'(instr_valid), 64'(mq.size() > 0));
    chk("imem_addr", 64'(imem_addr), 64'(mpc >> 2));
    if (mq.size() > 0) begin
      chk("instr", 64'(instr), 64'(mq[0].i));
      chk("instr_pc", 64'(instr_pc), 64'(mq[0].p));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  typedef struct {
    bit          rst;
    bit          en;
    bit          rdy;
    bit          exp_valid;
    logic [5:0]  exp_pc;
    logic [31:0] exp_instr;
    logic [3:0]  exp_addr;
  } vec_t;

  localparam logic [31:0] W0 = 32'h00002083;
  localparam logic [31:0] W1 = 32'h00802103;
  localparam logic [31:0] W2 = 32'h00002233;

  vec_t vecs[$];

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    mem[0]  = W0;
    mem[1]  = W1;
    mem[2]  = W2;
    mem[11] = 32'h0;

    vecs.push_back('{1, 0, 0, 0, 6'h00, 32'h0, 4'd0});
    vecs.push_back('{0, 1, 1, 0, 6'h00, 32'h0, 4'd0});
    vecs.push_back('{0, 1, 1, 1, 6'h00, W0,    4'd1});
    vecs.push_back('{0, 1, 1, 1, 6'h04, W1,    4'd2});
    vecs.push_back('{0, 1, 1, 1, 6'h08, W2,    4'd3});
    vecs.push_back('{1, 0, 0, 0, 6'h00, 32'h0, 4'd0});
    vecs.push_back('{0, 1, 0, 0, 6'h00, 32'h0, 4'd0});
    vecs.push_back('{0, 1, 0, 1, 6'h00, W0,    4'd1});
    vecs.push_back('{0, 1, 0, 1, 6'h00, W0,    4'd2});
    vecs.push_back('{0, 1, 0, 1, 6'h00, W0,    4'd2});
    vecs.push_back('{0, 1, 0, 1, 6'h00, W0,    4'd2});
    vecs.push_back('{0, 1, 1, 1, 6'h04, W1,    4'd3});
    vecs.push_back('{0, 1, 1, 1, 6'h08, W2,    4'd4});

    #2;
    chk("reset_valid", 64'(instr_valid), 64'd0);
    chk("reset_instr", 64'(instr), 64'd0);
    chk("reset_instr_pc", 64'(instr_pc), 64'd0);
    chk("reset_addr", 64'(imem_addr), 64'd0);

    foreach (vecs[n]) begin
      rst_n       = !vecs[n].rst;
      fetch_en    = vecs[n].en;
      instr_ready = vecs[n].rdy;
      tick();
      rst_n = 1'b1;
      chk($sformatf("vec%0d_valid", n), 64'(instr_valid), 64'(vecs[n].exp_valid));
      chk($sformatf("vec%0d_addr", n), 64'(imem_addr), 64'(vecs[n].exp_addr));
      if (vecs[n].exp_valid) begin
        chk($sformatf("vec%0d_pc", n), 64'(instr_pc), 64'(vecs[n].exp_pc));
        chk($sformatf("vec%0d_instr", n), 64'(instr), 64'(vecs[n].exp_instr));
      end
    end

    // Redirect to 0x2E while entries are queued.
    instr_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 6'h2E;
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush_valid", 64'(instr_valid), 64'd0);
    chk("redir_addr", 64'(imem_addr), 64'd11);
    tick();
    chk("redir_next_valid", 64'(instr_valid), 64'd1);
    chk("redir_next_pc", 64'(instr_pc), 64'h2C);
    chk("redir_next_instr", 64'(instr), 64'h0);

    // Wrap from the last word back to 0.
    redirect_valid = 1'b1;
    redirect_pc    = 6'h3C;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_pc0", 64'(instr_pc), 64'h3C);
    tick();
    chk("wrap_pc1", 64'(instr_pc), 64'h00);
    tick();
    chk("wrap_pc2", 64'(instr_pc), 64'h04);

    // Half-cycle asynchronous reset with the queue full.
    instr_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(instr_valid), 64'd0);
    chk("async_rst_pc", 64'(instr_pc), 64'd0);
    chk("async_rst_addr", 64'(imem_addr), 64'd0);
    mq.delete();
    mpc  = '0;
    mrun = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 64'(instr_valid), 64'd1);
    chk("post_rst_pc", 64'(instr_pc), 64'd0);
    chk("post_rst_instr", 64'(instr), 64'(W0));

    // Redirect, consumer ready and fetch opportunity all in one cycle.
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 6'h15;
    tick();
    redirect_valid = 1'b0;
    chk("prio_valid", 64'(instr_valid), 64'd0);
    chk("prio_addr", 64'(imem_addr), 64'd5);
    instr_ready = 1'b0;
    tick();
    chk("prio_next_pc", 64'(instr_pc), 64'h14);

    // Random traffic checked every cycle against the model.
    for (int c = 0; c < 600; c++) begin
      fetch_en       = ($urandom % 8) != 0;
      instr_ready    = $urandom % 2;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = 6'($urandom);
      rst_n          = ($urandom % 150) != 0;
      tick();
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
